mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the pipelined CPU's instruction-fetch port and data port share a single memory bus. It sits between the CPU and the unified memory/peripheral interconnect. It serialises each CPU cycle's data access and instruction fetch, latches the read results, and raises both CPU ready signals together for exactly one cycle so the pipeline advances once.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port to one-port memory arbiter:
// FSM state encoding, default watchdog limit and the abort data word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_ACC  = 2'd1,
    INSTR_ACC = 2'd2,
    DONE      = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Word returned to the CPU when an access is aborted by the watchdog.
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog for mem_arbiter (used only when MEM_ARB_TIMEOUT_EN is defined).
// Counts cycles while enable_i is high; expired_o fires in the cycle that
// would be the TIMEOUT_CYCLES-th cycle of the access without an ack.
module mem_arb_watchdog import mem_arb_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // Count value held during the last permitted cycle of an access.
  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // Cycle counter: cleared on ack / state change, advances while waiting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (enable_i) begin
      count <= count + 1'b1;
    end
  end

  assign expired_o = enable_i && (count == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: serialises the CPU data access and
// instruction fetch onto one bus, latches read results and pulses both
// ready signals together for one cycle.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add an access watchdog
// and the sticky err_o output.
//
// Handshake: the CPU presents requests and holds them stable while the
// readies are low; the readies are high for a single DONE cycle (or while
// idle with nothing requested). On the bus, a strobe is a request held
// until mem_ack_i, and the cycle after an ack is always a fresh request.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_rd_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic [31:0]       instr_data_o,
  output logic              instr_ready_o,
  input  logic              data_rd_i,
  input  logic              data_wr_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  input  logic [3:0]        data_byte_sel_i,
  output logic [31:0]       data_data_o,
  output logic              data_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [3:0]        mem_byte_sel_o,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        dbg_state_o
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              err_o
`endif
);

  arb_state_t state;
  arb_state_t state_next;

  logic        data_req;
  logic        any_req;
  logic        in_access;
  logic        abort;
  logic        acc_done;
  logic        ready;
  logic [31:0] capture_word;

  assign data_req  = data_rd_i | data_wr_i;
  assign any_req   = data_req | instr_rd_i;
  assign in_access = (state == DATA_ACC) || (state == INSTR_ACC);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;

  // Clears outside accesses and whenever the current access finishes,
  // so each access state entry starts counting from zero.
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (~in_access | acc_done),
    .enable_i  (in_access),
    .expired_o (expired)
  );

  assign abort = expired & ~mem_ack_i;
`else
  assign abort = 1'b0;
`endif

  // An abort finishes the access exactly as an ack would.
  assign acc_done     = mem_ack_i | abort;
  assign capture_word = abort ? ERR_WORD : mem_data_i;
  assign dbg_state_o  = state;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: data first (older instruction), then fetch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_req) begin
          state_next = DATA_ACC;
        end else if (instr_rd_i) begin
          state_next = INSTR_ACC;
        end
      end
      DATA_ACC: begin
        if (acc_done) begin
          state_next = instr_rd_i ? INSTR_ACC : DONE;
        end
      end
      INSTR_ACC: begin
        if (acc_done) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: bus mux, strobes and CPU readies.
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_rd_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_byte_sel_o = '0;
    ready          = (state == DONE) || ((state == IDLE) && !any_req);
    case (state)
      DATA_ACC: begin
        mem_addr_o     = data_addr_i;
        mem_data_o     = data_wdata_i;
        mem_byte_sel_o = data_byte_sel_i;
        // Read and write together is a write.
        mem_rd_o       = data_rd_i & ~data_wr_i;
        mem_wr_o       = data_wr_i;
      end
      INSTR_ACC: begin
        mem_addr_o     = instr_addr_i;
        mem_rd_o       = 1'b1;
        mem_byte_sel_o = 4'hF;
      end
      default: ;
    endcase
    instr_ready_o = ready;
    data_ready_o  = ready;
  end

  // Read-result latches, updated only when the matching access finishes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_data_o  <= '0;
      instr_data_o <= '0;
    end else begin
      if ((state == DATA_ACC) && acc_done && data_rd_i && !data_wr_i) begin
        data_data_o <= capture_word;
      end
      if ((state == INSTR_ACC) && acc_done) begin
        instr_data_o <= capture_word;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Sticky error flag, set by any watchdog abort.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (in_access && abort) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, hand-written reset /
// ready-pulse / timeout sequences, and randomized transactions checked
// against a transaction-level model (latency, captured words, bus accesses).
module tb_mem_arbiter;

  localparam int REC_W = 70; // {addr[31:0], wr, rd, byte_sel[3:0], wdata[31:0]}

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
  localparam int unsigned TB_TW      = 3;
`else
  localparam int unsigned TB_TIMEOUT = 255;
  localparam int unsigned TB_TW      = 8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        instr_rd;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        data_rd;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_bsel;
  logic [31:0] data_data;
  logic        data_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_bsel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  mem_arbiter #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .TIMEOUT_W      (TB_TW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .instr_rd_i      (instr_rd),
    .instr_addr_i    (instr_addr),
    .instr_data_o    (instr_data),
    .instr_ready_o   (instr_ready),
    .data_rd_i       (data_rd),
    .data_wr_i       (data_wr),
    .data_addr_i     (data_addr),
    .data_wdata_i    (data_wdata),
    .data_byte_sel_i (data_bsel),
    .data_data_o     (data_data),
    .data_ready_o    (data_ready),
    .mem_addr_o      (mem_addr),
    .mem_data_o      (mem_wdata),
    .mem_rd_o        (mem_rd),
    .mem_wr_o        (mem_wr),
    .mem_byte_sel_o  (mem_bsel),
    .mem_data_i      (mem_rdata),
    .mem_ack_i       (mem_ack),
    .dbg_state_o     (dbg_state)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .err_o           (err)
`endif
  );

  // ---------------- memory model ----------------
  // Access k waits wait_tab[k] cycles before acking with rdata_tab[k];
  // every acked access is logged as a record.
  logic             mem_clr = 1'b1;
  int               acc_idx;
  int               wait_cnt;
  int               wr_cycles;
  int               wait_tab[4];
  logic [31:0]      rdata_tab[4];
  logic [REC_W-1:0] log_tab[4];
  logic             strobe;

  assign strobe    = mem_rd | mem_wr;
  assign mem_ack   = strobe && !mem_clr && (acc_idx < 4) && (wait_cnt >= wait_tab[acc_idx[1:0]]);
  assign mem_rdata = mem_ack ? rdata_tab[acc_idx[1:0]] : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (mem_clr) begin
      acc_idx   <= 0;
      wait_cnt  <= 0;
      wr_cycles <= 0;
    end else begin
      if (mem_wr) wr_cycles <= wr_cycles + 1;
      if (mem_ack) begin
        log_tab[acc_idx[1:0]] <= {mem_addr, mem_wr, mem_rd, mem_bsel, mem_wdata};
        acc_idx  <= acc_idx + 1;
        wait_cnt <= 0;
      end else if (strobe) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int               tests = 0;
  int               fails = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          ird;
    bit          drd;
    bit          dwr;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
    int          wd;
    int          wi;
    logic [31:0] rd_d;
    logic [31:0] rd_i;
    int          exp_lat;
    logic [31:0] exp_id;
    logic [31:0] exp_dd;
    int          exp_wr;
    bit          hold;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    instr_rd   = 1'b0;
    instr_addr = '0;
    data_rd    = 1'b0;
    data_wr    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    data_bsel  = '0;
  endtask

  // Runs one CPU cycle's request; entered and left just after a posedge.
  // With v.hold the inputs stay asserted one cycle past the ready pulse.
  task automatic run_vec(input string tag, input vec_t v);
    int  lat;
    bit  eq_ok;
    bit  has_data;
    int  n;
    has_data     = v.drd | v.dwr;
    mem_clr      = 1'b1;
    wait_tab[0]  = has_data ? v.wd : v.wi;
    rdata_tab[0] = has_data ? v.rd_d : v.rd_i;
    wait_tab[1]  = v.wi;
    rdata_tab[1] = v.rd_i;
    wait_tab[2]  = 1000;
    wait_tab[3]  = 1000;
    exp_q.delete();
    if (has_data) exp_q.push_back({v.daddr, v.dwr, v.drd & ~v.dwr, v.bsel, v.wdata});
    if (v.ird)    exp_q.push_back({v.iaddr, 1'b0, 1'b1, 4'hF, 32'h0});
    @(posedge clk); #1;
    mem_clr    = 1'b0;
    instr_rd   = v.ird;
    instr_addr = v.iaddr;
    data_rd    = v.drd;
    data_wr    = v.dwr;
    data_addr  = v.daddr;
    data_wdata = v.wdata;
    data_bsel  = v.bsel;
    lat   = -1;
    eq_ok = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (instr_ready !== data_ready) eq_ok = 1'b0;
      if (instr_ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, " readies_equal"}, REC_W'(eq_ok), REC_W'(1));
    check({tag, " latency"}, REC_W'(lat), REC_W'(v.exp_lat));
    if (v.hold) begin
      @(negedge clk);
      check({tag, " ready_one_cycle"}, REC_W'({instr_ready, data_ready}), REC_W'(2'b00));
    end else begin
      @(posedge clk); #1;
      drive_idle();
    end
    check({tag, " instr_data"}, REC_W'(instr_data), REC_W'(v.exp_id));
    check({tag, " data_data"}, REC_W'(data_data), REC_W'(v.exp_dd));
    check({tag, " write_cycles"}, REC_W'(wr_cycles), REC_W'(v.exp_wr));
    check({tag, " access_count"}, REC_W'(acc_idx), REC_W'(exp_q.size()));
    n = 0;
    while (exp_q.size() > 0) begin
      logic [REC_W-1:0] e;
      e = exp_q.pop_front();
      if (n < 4) check({tag, " bus_access"}, log_tab[n], e);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[6];
  logic [31:0] m_id;
  logic [31:0] m_dd;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_state", REC_W'(dbg_state), REC_W'(2'd0));
    check("rst_instr_data", REC_W'(instr_data), REC_W'(0));
    check("rst_data_data", REC_W'(data_data), REC_W'(0));
    check("rst_strobes", REC_W'({mem_rd, mem_wr}), REC_W'(2'b00));
`ifdef MEM_ARB_TIMEOUT_EN
    check("rst_err", REC_W'(err), REC_W'(0));
`endif
    rst_i = 1'b1;
    @(posedge clk); #1;

    // No request: readies high, bus quiet
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_readies", REC_W'({instr_ready, data_ready}), REC_W'(2'b11));
      check("idle_bus", REC_W'({mem_rd, mem_wr, mem_addr, mem_bsel}), REC_W'(0));
    end

    // Directed vector table (expectations chain: latched words persist)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 0,
                32'h0, 32'h00500093, 2, 32'h00500093, 32'h0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h14, 32'h200, 32'hCAFE0001, 4'hF, 0, 0,
                32'h0, 32'h00000013, 3, 32'h00000013, 32'h0, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h18, 32'h204, 32'h0, 4'hF, 2, 2,
                32'h11223344, 32'h55667788, 7, 32'h55667788, 32'h11223344, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h208, 32'h0000BEEF, 4'h3, 1, 0,
                32'h99999999, 32'h0, 3, 32'h55667788, 32'h11223344, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20C, 32'h0, 4'hC, 0, 0,
                32'hA5A50F0F, 32'h0, 2, 32'h55667788, 32'hA5A50F0F, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0,
                32'h0, 32'h0, 0, 32'h55667788, 32'hA5A50F0F, 0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Ready pulse lasts one cycle; inputs stay held so a new data access
    // starts, and reset is asserted in the middle of it.
    v = '{1'b1, 1'b1, 1'b0, 32'h30, 32'h300, 32'h0, 4'hF, 1, 2,
          32'h0F0F1234, 32'h00A00113, 6, 32'h00A00113, 32'h0F0F1234, 0, 1'b1};
    run_vec("pulse", v);
    @(posedge clk); #3;
    check("mid_acc_state", REC_W'(dbg_state), REC_W'(2'd1));
    check("mid_acc_rd", REC_W'(mem_rd), REC_W'(1));
    rst_i = 1'b0;
    #1;
    check("rst_mid_strobes", REC_W'({mem_rd, mem_wr}), REC_W'(2'b00));
    check("rst_mid_addr", REC_W'(mem_addr), REC_W'(0));
    check("rst_mid_state", REC_W'(dbg_state), REC_W'(2'd0));
    check("rst_mid_data", REC_W'({instr_data, data_data}), REC_W'(0));
    mem_clr = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("post_rst_readies", REC_W'({instr_ready, data_ready}), REC_W'(2'b11));
    v = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 0,
          32'h0, 32'h00100073, 2, 32'h00100073, 32'h0, 0, 1'b0};
    run_vec("post_rst_fetch", v);

    // Randomized transactions against a transaction-level model
    m_id = 32'h00100073;
    m_dd = 32'h0;
    for (int i = 0; i < 40; i++) begin
      bit has_data;
      v.ird   = 1'($urandom_range(0, 1));
      v.drd   = 1'($urandom_range(0, 1));
      v.dwr   = 1'($urandom_range(0, 1));
      v.iaddr = $urandom & 32'hFFFF_FFFC;
      v.daddr = $urandom;
      v.wdata = $urandom;
      v.bsel  = 4'($urandom_range(0, 15));
      v.wd    = int'($urandom_range(0, 3));
      v.wi    = int'($urandom_range(0, 3));
      v.rd_d  = $urandom;
      v.rd_i  = $urandom;
      v.hold  = 1'b0;
      has_data = v.drd | v.dwr;
      if (v.ird | has_data)
        v.exp_lat = 1 + (has_data ? 1 + v.wd : 0) + (v.ird ? 1 + v.wi : 0);
      else
        v.exp_lat = 0;
      if (v.drd && !v.dwr) m_dd = v.rd_d;
      if (v.ird) m_id = v.rd_i;
      v.exp_id = m_id;
      v.exp_dd = m_dd;
      v.exp_wr = v.dwr ? 1 + v.wd : 0;
      run_vec($sformatf("rand%0d", i), v);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Fetch that never gets an ack: aborted after TB_TIMEOUT strobe cycles
    begin
      int lat;
      mem_clr      = 1'b1;
      wait_tab[0]  = 1000;
      rdata_tab[0] = 32'h0;
      @(posedge clk); #1;
      mem_clr    = 1'b0;
      instr_rd   = 1'b1;
      instr_addr = 32'h50;
      lat = -1;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (instr_ready === 1'b1) begin
          lat = c;
          break;
        end
      end
      check("to_latency", REC_W'(lat), REC_W'(1 + TB_TIMEOUT));
      check("to_instr_data", REC_W'(instr_data), REC_W'(32'hDEADBEEF));
      check("to_err", REC_W'(err), REC_W'(1));
      check("to_no_ack", REC_W'(acc_idx), REC_W'(0));
      @(posedge clk); #1;
      drive_idle();
      v = '{1'b1, 1'b0, 1'b0, 32'h54, 32'h0, 32'h0, 4'h0, 0, 0,
            32'h0, 32'h12345678, 2, 32'h12345678, m_dd, 0, 1'b0};
      run_vec("to_after", v);
      check("to_err_sticky", REC_W'(err), REC_W'(1));
      rst_i = 1'b0;
      #1;
      check("to_err_reset", REC_W'(err), REC_W'(0));
      @(posedge clk); #1;
      rst_i = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
